// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the serial-link UART blocks.
//
// Contents:
//   tx_state_t     - transmitter FSM states (IDLE, TRANSMIT)
//   DEF_CLK_FREQ   - default system clock frequency in Hz
//   DEF_BAUD_RATE  - default line rate in baud
//   FRAME_BITS     - line bits per frame: 10 for 8N1, 11 with even parity
//   build_frame()  - frame image in shift order (bit 0 goes out first)
//
// Build option: define UART_TX_PARITY_EN to insert an even parity bit
// between data bit 7 and the stop bit. The receiver on the other end of
// the link must be built with the same setting.
package uart_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        TRANSMIT = 1'b1
    } tx_state_t;

    localparam int DEF_CLK_FREQ  = 50000000;
    localparam int DEF_BAUD_RATE = 19200;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    // Frame image: stop bit at the top, start bit at the bottom.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^data, data, 1'b0};
`else
        return {1'b1, data, 1'b0};
`endif
    endfunction

endpackage

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, one byte per trmt strobe, LSB first, at
// CLK_FREQ/BAUD_RATE clocks per bit.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   trmt       in   transmit request strobe, accepted only while idle
//   tx_data    in   byte to send, sampled only on the accepting edge
//   TX         out  serial line, idle high, driven from a flop
//   tx_done    out  sticky frame-complete flag, cleared by the next accept
//   busy       out  high while a frame is on the line
//   state_dbg  out  current FSM state
//
// Handshake: a request is taken on any rising edge where trmt is high and
// the FSM is IDLE (busy low); requests while busy are dropped, not queued.
//
// Build option: UART_TX_PARITY_EN (see uart_pkg) adds an even parity bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = DEF_CLK_FREQ,
    parameter int BAUD_RATE = DEF_BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done,
    output logic       busy,
    output tx_state_t  state_dbg
);

    localparam int BAUD_CNT_REF = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = $clog2(BAUD_CNT_REF + 1);

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BAUD_CNT_REF);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [3:0]       FRAME_LEN  = 4'(FRAME_BITS);

    tx_state_t              state_q, state_d;
    logic [FRAME_BITS-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]       baud_cnt_q, baud_cnt_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic                   tx_done_q, tx_done_d;
    logic                   tx_q, tx_d;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_done_d  = tx_done_q;

        case (state_q)
            IDLE: begin
                if (trmt) begin
                    shift_d    = build_frame(tx_data);
                    bit_cnt_d  = 4'd0;
                    baud_cnt_d = CNT_RELOAD;
                    tx_done_d  = 1'b0;
                    state_d    = TRANSMIT;
                end
            end
            TRANSMIT: begin
                // The counter is loaded with the full bit period and the
                // shift happens on the edge that would take it to zero, so
                // every bit lasts exactly BAUD_CNT_REF cycles.
                if (baud_cnt_q == CNT_ONE) begin
                    shift_d    = {1'b1, shift_q[FRAME_BITS-1:1]};
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    baud_cnt_d = CNT_RELOAD;
                    if (bit_cnt_d == FRAME_LEN) begin
                        state_d   = IDLE;
                        tx_done_d = 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Line flop follows the next shift image so the start bit is on the
        // line right after the accepting edge.
        tx_d = shift_d[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '1;
            baud_cnt_q <= '0;
            bit_cnt_q  <= 4'd0;
            tx_done_q  <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_done_q  <= tx_done_d;
            tx_q       <= tx_d;
        end
    end

    assign TX        = tx_q;
    assign tx_done   = tx_done_q;
    assign busy      = (state_q == TRANSMIT);
    assign state_dbg = state_q;

endmodule
